// File: rtl/video_pattern_gen_pkg.sv
// Shared types and constants for the video pattern generator:
// RGB565 colour constants, pattern encodings and FSM states.
package video_pattern_gen_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_GRAY    = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Colour-bar palette, left to right.
    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = RGB_WHITE;
            3'd1:    bar_color = RGB_YELLOW;
            3'd2:    bar_color = RGB_CYAN;
            3'd3:    bar_color = RGB_GREEN;
            3'd4:    bar_color = RGB_MAGENTA;
            3'd5:    bar_color = RGB_RED;
            3'd6:    bar_color = RGB_BLUE;
            default: bar_color = RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vpg_pixel.sv
// Combinational pattern generator: maps pattern, pixel position and solid
// colour to one RGB565 value.
module vpg_pixel
    import video_pattern_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640
) (
    input  pattern_e    pattern,
    input  logic [15:0] h_cnt,
    input  logic [15:0] v_cnt,
    input  logic [15:0] solid_color,
    output logic [15:0] pixel
);

    localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);

    logic [2:0] bar_idx;
    logic       unused_v;

    // Only bit 4 of the line counter matters (16-line checker rows).
    assign unused_v = ^{v_cnt[15:5], v_cnt[3:0]};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        pixel   = RGB_BLACK;
        bar_idx = 3'(h_cnt / BAR_W);
        case (pattern)
            PAT_SOLID:   pixel = solid_color;
            PAT_BARS:    pixel = bar_color(bar_idx);
            PAT_GRAY:    pixel = {h_cnt[7:3], h_cnt[7:2], h_cnt[7:3]};
            PAT_CHECKER: pixel = (h_cnt[4] ^ v_cnt[4]) ? RGB_WHITE : RGB_BLACK;
            default:     pixel = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Frame timing generator with selectable test patterns; a two-stage pipeline
// (count snapshot, then registered outputs) drives the video interface.
module video_pattern_gen
    import video_pattern_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_BLANK  = 160,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_BLANK  = 45
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        per_frame_vsync,
    output logic        per_frame_href,
    output logic        per_frame_clken,
    output logic [15:0] img_data,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);

    state_e        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    pattern_e      frame_pat_q, frame_pat_d;
    logic [15:0]   frame_solid_q, frame_solid_d;

    // Stage 1: snapshot of the current count and its geometry flags.
    logic          s1_vsync_q, s1_vsync_d;
    logic          s1_href_q, s1_href_d;
    logic          s1_last_q, s1_last_d;
    logic [HW-1:0] s1_h_q, s1_h_d;
    logic [VW-1:0] s1_v_q, s1_v_d;

    // Stage 2: registered outputs.
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [15:0]   img_q, img_d;
    logic          done_q, done_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;

    logic [15:0]   pixel;
    logic          line_end;
    logic          frame_end;

    vpg_pixel #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pixel (
        .pattern     (frame_pat_q),
        .h_cnt       (16'(s1_h_q)),
        .v_cnt       (16'(s1_v_q)),
        .solid_color (frame_solid_q),
        .pixel       (pixel)
    );

    assign line_end  = (h_cnt_q == H_LAST);
    assign frame_end = line_end && (v_cnt_q == V_LAST);

    always_comb begin
        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_pat_d   = frame_pat_q;
        frame_solid_d = frame_solid_q;
        s1_vsync_d    = 1'b0;
        s1_href_d     = 1'b0;
        s1_last_d     = 1'b0;
        s1_h_d        = '0;
        s1_v_d        = '0;

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                s1_vsync_d = (v_cnt_q < V_ACT_C);
                s1_href_d  = s1_vsync_d && (h_cnt_q < H_ACT_C);
                s1_last_d  = frame_end;
                s1_h_d     = h_cnt_q;
                s1_v_d     = v_cnt_q;
                // Pattern settings are frozen for the whole frame at its first count.
                if (h_cnt_q == '0 && v_cnt_q == '0) begin
                    frame_pat_d   = pattern_e'(pattern_sel);
                    frame_solid_d = solid_color;
                end
                if (line_end) begin
                    h_cnt_d = '0;
                    if (frame_end) begin
                        v_cnt_d = '0;
                        if (!enable) state_d = ST_IDLE;
                    end else begin
                        v_cnt_d = v_cnt_q + 1'b1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        vsync_d     = s1_vsync_q;
        href_d      = s1_href_q;
        img_d       = s1_href_q ? pixel : RGB_BLACK;
        done_d      = s1_last_q;
        frame_cnt_d = frame_cnt_q + {7'd0, s1_last_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_pat_q   <= PAT_SOLID;
            frame_solid_q <= '0;
            s1_vsync_q    <= 1'b0;
            s1_href_q     <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_h_q        <= '0;
            s1_v_q        <= '0;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            img_q         <= '0;
            done_q        <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_pat_q   <= frame_pat_d;
            frame_solid_q <= frame_solid_d;
            s1_vsync_q    <= s1_vsync_d;
            s1_href_q     <= s1_href_d;
            s1_last_q     <= s1_last_d;
            s1_h_q        <= s1_h_d;
            s1_v_q        <= s1_v_d;
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            img_q         <= img_d;
            done_q        <= done_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign per_frame_vsync = vsync_q;
    assign per_frame_href  = href_q;
    assign per_frame_clken = href_q;
    assign img_data        = img_q;
    assign frame_done      = done_q;
    assign frame_cnt       = frame_cnt_q;

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line; must be a multiple of 8.
REQ-002 SHALL have parameter H_BLANK, default 160, blank clocks per line.
REQ-003 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 SHALL have parameter V_BLANK, default 45, blank lines per frame.
REQ-005 SHALL have port clk, input, 1 bit, single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-007 SHALL have port enable, input, 1 bit, request frame generation.
REQ-008 SHALL have port pattern_sel, input, 2 bits: 0 solid, 1 colour bars, 2 gray ramp, 3 checkerboard.
REQ-009 SHALL have port solid_color, input, 16 bits, RGB565 value for pattern 0.
REQ-010 SHALL have port per_frame_vsync, output, 1 bit, high for all active lines of a frame.
REQ-011 SHALL have port per_frame_href, output, 1 bit, high during active pixels of active lines.
REQ-012 SHALL have port per_frame_clken, output, 1 bit, pixel-valid strobe; equals per_frame_href (one pixel per clock).
REQ-013 SHALL have port img_data, output, 16 bits, RGB565 pixel; 0 whenever per_frame_clken=0.
REQ-014 SHALL have port frame_done, output, 1 bit, one-clock pulse at end of each frame.
REQ-015 SHALL have port frame_cnt, output, 8 bits, completed-frame count.

Function
REQ-016 FSM states: IDLE, RUN; IDLE->RUN when enable=1; RUN->IDLE at end of a frame when enable=0; otherwise RUN continues into the next frame.
REQ-017 In RUN: h_cnt counts 0..H_ACTIVE+H_BLANK-1 and wraps; v_cnt increments on h_cnt wrap and counts 0..V_ACTIVE+V_BLANK-1, then wraps.
REQ-018 Frame geometry: vsync = (v_cnt<V_ACTIVE); href = vsync && (h_cnt<H_ACTIVE).
REQ-019 All outputs registered: first vsync/href/clken high exactly 2 clocks after the edge that samples enable=1 in IDLE.
REQ-020 Deasserting enable mid-frame SHALL NOT truncate the frame; the current frame completes, then the block enters IDLE with all outputs 0.
REQ-021 pattern_sel and solid_color sampled only at frame start (h_cnt=0, v_cnt=0); mid-frame changes take effect next frame.
REQ-022 Pattern 1: 8 equal-width bars, index = h_cnt/(H_ACTIVE/8), colours in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-023 Pattern 2: gray = h_cnt[7:0]; img_data = {gray[7:3], gray[7:2], gray[7:3]}; wraps every 256 pixels.
REQ-024 Pattern 3: img_data = FFFF if h_cnt[4]^v_cnt[4] else 0000 (16x16 squares).
REQ-025 frame_done pulses for 1 clock, aligned with the output cycle of the last count (h_cnt, v_cnt both at max).
REQ-026 frame_cnt increments on the same cycle as frame_done; it wraps 255->0.
REQ-027 enable toggling in IDLE for 1 clock SHALL still start and complete one full frame.

Reset
REQ-028 rst_n low SHALL immediately force the state to IDLE, counters to 0, all outputs (vsync, href, clken, img_data, frame_done, frame_cnt) to 0, including mid-frame.
REQ-029 After rst_n release, no output activity until enable is sampled high.

Structure
REQ-030 A shared package/include SHALL hold RGB565 colour constants, pattern_sel encodings, and FSM state encodings.
REQ-031 One sub-module, vpg_pixel: combinational (pattern, h_cnt, v_cnt, solid_color) -> RGB565; timing counters and FSM stay in top.

Verification (H_ACTIVE=16, H_BLANK=4, V_ACTIVE=4, V_BLANK=2)
REQ-032 Bench: enable=1, pattern 0, solid_color=001F -> href high for 16 clocks per line, 4 lines per frame; 64 pixels, all 001F; line period 20 clocks; frame period 120 clocks.
REQ-033 Bench: pattern 1 -> each line yields 2 pixels each of FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000 in order.
REQ-034 Bench: enable dropped at pixel 30 of a frame -> all 64 pixels still emitted, frame_done pulses once, frame_cnt=1, then outputs stay 0.
REQ-035 Bench: rst_n pulsed low mid-line 2 -> all outputs 0 in the same cycle; with enable still 1 after release, first href occurs 2 clocks after the first sampling edge.
REQ-036 Bench: pattern_sel changed 1->3 mid-frame -> current frame stays bars; next frame is checkerboard (with a 16-wide frame and v_cnt<16: row 0 yields 0000 for all pixels).
REQ-037 Bench: run 256 frames -> frame_cnt wraps to 0, and frame_done pulse count equals 256.
